// File: rtl/pingpong_buffer.sv
// Two-bank ping-pong frame buffer: the writer fills one bank while the reader
// consumes the other; a bank is handed to the reader once a complete frame lands in it.
module pingpong_buffer #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 784,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic [WORD_SIZE-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 wr_sel,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic                 rd_done,
  output logic                 rd_ready,
  output logic                 rd_sel,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic                 rd_data_valid,
  output logic [15:0]          frame_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  logic [WORD_SIZE-1:0] bank0 [DEPTH];
  logic [WORD_SIZE-1:0] bank1 [DEPTH];

  logic [ADDR_W-1:0]    wr_addr;
  logic [1:0]           full;
  logic [1:0]           full_nxt;
  logic                 wr_fire;
  logic                 frame_end;
  logic                 rd_fire;
  logic                 rd_release;
  logic                 rd_oob;
  logic [WORD_SIZE-1:0] rd_word;

  assign wr_ready   = !reset && !full[wr_sel];
  assign rd_ready   = full[rd_sel];
  assign wr_fire    = wr_valid && wr_ready;
  assign frame_end  = wr_fire && (wr_addr == LAST_ADDR);
  assign rd_fire    = !reset && rd_en && rd_ready;
  assign rd_release = !reset && rd_done && rd_ready;
  assign rd_oob     = ({1'b0, rd_addr} >= DEPTH_X);

  // Set wins over clear so a bank can never be lost when both hit it at once.
  always_comb begin
    full_nxt = full;
    if (rd_release) full_nxt[rd_sel] = 1'b0;
    if (frame_end)  full_nxt[wr_sel] = 1'b1;
  end

  always_comb begin
    rd_word = '0;
    if (!rd_oob) rd_word = rd_sel ? bank1[rd_addr] : bank0[rd_addr];
  end

  // Bank storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_sel) bank1[wr_addr] <= wr_data;
      else        bank0[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      wr_addr       <= '0;
      full          <= 2'b00;
      rd_data       <= '0;
      rd_data_valid <= 1'b0;
      frame_count   <= '0;
    end else begin
      full          <= full_nxt;
      rd_data_valid <= rd_fire;
      if (rd_fire) rd_data <= rd_word;
      if (rd_release) rd_sel <= !rd_sel;
      if (frame_end) begin
        wr_sel      <= !wr_sel;
        wr_addr     <= '0;
        frame_count <= frame_count + 16'd1;
      end else if (wr_fire) begin
        wr_addr <= wr_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_buffer.sv
// Bench for pingpong_buffer at DEPTH=4: a vector table of per-cycle inputs and
// expected outputs, read results checked one cycle later through a queue.
module tb_pingpong_buffer;

  localparam int WS = 16;
  localparam int DP = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_valid;
  logic [WS-1:0] wr_data;
  logic          wr_ready;
  logic          wr_sel;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          rd_done;
  logic          rd_ready;
  logic          rd_sel;
  logic [WS-1:0] rd_data;
  logic          rd_data_valid;
  logic [15:0]   frame_count;

  pingpong_buffer #(.WORD_SIZE(WS), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_sel(wr_sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done),
    .rd_ready(rd_ready), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          wv;
    logic [WS-1:0] wd;
    logic          re;
    logic [AW-1:0] ra;
    logic          rdn;
    logic          wrdy;
    logic          rrdy;
    logic          ws;
    logic          rs;
    logic [15:0]   fc;
    logic          nv;
    logic [WS-1:0] nd;
  } vec_t;

  typedef struct {
    logic          v;
    logic [WS-1:0] d;
  } rd_exp_t;

  vec_t    tq[$];
  rd_exp_t sb[$];
  int      n_vec = 0;
  int      n_err = 0;

  function automatic vec_t mk(logic rst, logic wv, logic [WS-1:0] wd, logic re,
                              logic [AW-1:0] ra, logic rdn, logic wrdy, logic rrdy,
                              logic ws, logic rs, logic [15:0] fc, logic nv,
                              logic [WS-1:0] nd);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wd = wd; v.re = re; v.ra = ra; v.rdn = rdn;
    v.wrdy = wrdy; v.rrdy = rrdy; v.ws = ws; v.rs = rs; v.fc = fc;
    v.nv = nv; v.nd = nd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pops the read result of the previous edge, then drives this cycle's inputs.
  task automatic drive(input logic rst, input logic wv, input logic [WS-1:0] wd,
                       input logic re, input logic [AW-1:0] ra, input logic rdn,
                       input logic nv, input logic [WS-1:0] nd);
    rd_exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data_valid", 32'(rd_data_valid), 32'(e.v));
      chk("rd_data", 32'(rd_data), 32'(e.d));
    end
    reset = rst; wr_valid = wv; wr_data = wd; rd_en = re; rd_addr = ra; rd_done = rdn;
    #1;
    e.v = nv; e.d = nd;
    sb.push_back(e);
    n_vec++;
  endtask

  task automatic chk_state(input logic wrdy, input logic rrdy, input logic ws,
                           input logic rs, input logic [15:0] fc);
    chk("wr_ready", 32'(wr_ready), 32'(wrdy));
    chk("rd_ready", 32'(rd_ready), 32'(rrdy));
    chk("wr_sel", 32'(wr_sel), 32'(ws));
    chk("rd_sel", 32'(rd_sel), 32'(rs));
    chk("frame_count", 32'(frame_count), 32'(fc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b1; wr_valid = 0; wr_data = '0; rd_en = 0; rd_addr = '0; rd_done = 0;
    repeat (2) @(posedge clk);

    //          rst wv wd     re ra rdn  wrdy rrdy ws rs fc  nv nd
    tq.push_back(mk(1, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 0, 16'h0, 1, 2, 0, 1, 1, 1, 0, 1, 1, 16'h3));
    tq.push_back(mk(0, 0, 16'h0, 1, 5, 0, 1, 1, 1, 0, 1, 1, 16'h0));
    tq.push_back(mk(0, 0, 16'h0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 16'h1));
    tq.push_back(mk(0, 1, 16'h5, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h1));
    tq.push_back(mk(0, 1, 16'h6, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h1));
    tq.push_back(mk(0, 1, 16'h7, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h1));
    tq.push_back(mk(0, 1, 16'h8, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h1));
    tq.push_back(mk(0, 1, 16'h9, 0, 0, 0, 0, 1, 0, 0, 2, 0, 16'h1));
    tq.push_back(mk(0, 1, 16'h9, 1, 3, 1, 0, 1, 0, 0, 2, 1, 16'h4));
    tq.push_back(mk(0, 1, 16'h9, 0, 0, 0, 1, 1, 0, 1, 2, 0, 16'h4));
    tq.push_back(mk(0, 0, 16'h0, 1, 0, 0, 1, 1, 0, 1, 2, 1, 16'h5));
    tq.push_back(mk(0, 1, 16'hA, 0, 0, 0, 1, 1, 0, 1, 2, 0, 16'h5));
    tq.push_back(mk(0, 1, 16'hB, 0, 0, 0, 1, 1, 0, 1, 2, 0, 16'h5));
    tq.push_back(mk(0, 1, 16'hC, 0, 0, 1, 1, 1, 0, 1, 2, 0, 16'h5));
    tq.push_back(mk(0, 0, 16'h0, 1, 0, 0, 1, 1, 1, 0, 3, 1, 16'h9));
    tq.push_back(mk(0, 0, 16'h0, 1, 3, 0, 1, 1, 1, 0, 3, 1, 16'hC));
    tq.push_back(mk(0, 0, 16'h0, 0, 0, 1, 1, 1, 1, 0, 3, 0, 16'hC));
    tq.push_back(mk(0, 0, 16'h0, 1, 1, 0, 1, 0, 1, 1, 3, 0, 16'hC));
    tq.push_back(mk(0, 0, 16'h0, 1, 2, 0, 1, 0, 1, 1, 3, 0, 16'hC));
    tq.push_back(mk(0, 0, 16'h0, 0, 0, 1, 1, 0, 1, 1, 3, 0, 16'hC));
    tq.push_back(mk(0, 1, 16'h21, 0, 0, 0, 1, 0, 1, 1, 3, 0, 16'hC));
    tq.push_back(mk(0, 1, 16'h22, 0, 0, 0, 1, 0, 1, 1, 3, 0, 16'hC));
    tq.push_back(mk(1, 1, 16'h99, 1, 0, 1, 0, 0, 1, 1, 3, 0, 16'h0));
    tq.push_back(mk(0, 0, 16'h0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h31, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h32, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h33, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 1, 16'h34, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'h0));
    tq.push_back(mk(0, 0, 16'h0, 1, 0, 0, 1, 1, 1, 0, 1, 1, 16'h31));
    tq.push_back(mk(0, 0, 16'h0, 1, 1, 0, 1, 1, 1, 0, 1, 1, 16'h32));
    tq.push_back(mk(0, 0, 16'h0, 1, 2, 0, 1, 1, 1, 0, 1, 1, 16'h33));
    tq.push_back(mk(0, 0, 16'h0, 1, 3, 0, 1, 1, 1, 0, 1, 1, 16'h34));
    tq.push_back(mk(0, 0, 16'h0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h34));
    tq.push_back(mk(0, 1, 16'h41, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h34));
    tq.push_back(mk(0, 1, 16'h42, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h34));
    tq.push_back(mk(0, 1, 16'h43, 0, 0, 0, 1, 1, 1, 0, 1, 0, 16'h34));
    tq.push_back(mk(0, 1, 16'h44, 0, 0, 1, 1, 1, 1, 0, 1, 0, 16'h34));
    tq.push_back(mk(0, 0, 16'h0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 16'h34));
    tq.push_back(mk(0, 0, 16'h0, 1, 3, 0, 1, 1, 0, 1, 2, 1, 16'h44));
    tq.push_back(mk(0, 0, 16'h0, 0, 0, 0, 1, 1, 0, 1, 2, 0, 16'h44));

    for (int i = 0; i < tq.size(); i++) begin
      v = tq[i];
      drive(v.rst, v.wv, v.wd, v.re, v.ra, v.rdn, v.nv, v.nd);
      chk_state(v.wrdy, v.rrdy, v.ws, v.rs, v.fc);
    end

    // Both banks full: the offered word must wait for rd_done, then land at address 0.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 16'(16'h51 + i), 0, 0, 0, 0, 16'h44);
      chk_state(1, 1, 0, 1, 2);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 16'h60, 0, 0, 0, 0, 16'h44);
      chk_state(0, 1, 1, 1, 3);
    end
    drive(0, 1, 16'h60, 0, 0, 1, 0, 16'h44);
    chk_state(0, 1, 1, 1, 3);
    drive(0, 1, 16'h60, 0, 0, 0, 0, 16'h44);
    chk_state(1, 1, 1, 0, 3);
    drive(0, 0, 16'h0, 1, 0, 0, 1, 16'h51);
    chk_state(1, 1, 1, 0, 3);
    drive(0, 0, 16'h0, 0, 0, 1, 0, 16'h51);
    chk_state(1, 1, 1, 0, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 16'(16'h61 + i), 0, 0, 0, 0, 16'h51);
      chk_state(1, 0, 1, 1, 3);
    end
    drive(0, 0, 16'h0, 1, 0, 0, 1, 16'h60);
    chk_state(1, 1, 0, 1, 4);
    drive(0, 0, 16'h0, 0, 0, 0, 0, 16'h60);
    drive(0, 0, 16'h0, 0, 0, 0, 0, 16'h60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
